// File: rtl/regfile_dump_pkg.sv
// Shared types and sizing for the register-file dump walker.
package regfile_dump_pkg;

  localparam int unsigned NUM_REGS = 8;
  localparam int unsigned DATA_W   = 16;
  localparam int unsigned IDX_W    = 3;

  typedef enum logic [1:0] {
    IDLE,
    SELECT,
    SEND,
    FINISH
  } dump_state_t;

endpackage

// File: rtl/regfile_next_idx.sv
// Priority encoder: next set mask bit strictly above idx, or the lowest set bit when from_start.
module regfile_next_idx
  import regfile_dump_pkg::*;
(
  input  logic [NUM_REGS-1:0] mask,
  input  logic [IDX_W-1:0]    idx,
  input  logic                from_start,
  output logic [IDX_W-1:0]    next_idx,
  output logic                found
);

  // Scan downward so the last hit is the lowest qualifying index.
  always_comb begin
    next_idx = '0;
    found    = 1'b0;
    for (int i = NUM_REGS - 1; i >= 0; i--) begin
      if (mask[i] && (from_start || (i > int'(idx)))) begin
        next_idx = IDX_W'(i);
        found    = 1'b1;
      end
    end
  end

endmodule

// File: rtl/regfile_dump.sv
// Walks masked registers of the 8x16 register file and streams {index, value} pairs out.
module regfile_dump
  import regfile_dump_pkg::*;
(
  input  logic                Clk,
  input  logic                Reset,
  input  logic                Start,
  input  logic [NUM_REGS-1:0] Mask,
  output logic [IDX_W-1:0]    Rd_sel,
  input  logic [DATA_W-1:0]   Rd_data,
  output logic                Out_valid,
  input  logic                Out_ready,
  output logic [DATA_W-1:0]   Out_data,
  output logic [IDX_W-1:0]    Out_idx,
  output logic                Busy,
  output logic                Done
);

  dump_state_t         state_q, state_d;
  logic [NUM_REGS-1:0] mask_q, mask_d;
  logic [IDX_W-1:0]    rd_sel_q, rd_sel_d;
  logic [DATA_W-1:0]   out_data_q, out_data_d;
  logic [IDX_W-1:0]    out_idx_q, out_idx_d;

  logic                enc_from_start;
  logic [NUM_REGS-1:0] enc_mask;
  logic [IDX_W-1:0]    enc_next;
  logic                enc_found;

  // In IDLE the live Mask input seeds the first pick; afterwards only the latched copy is used.
  assign enc_from_start = (state_q == IDLE);
  assign enc_mask       = enc_from_start ? Mask : mask_q;

  regfile_next_idx u_next_idx (
    .mask       (enc_mask),
    .idx        (rd_sel_q),
    .from_start (enc_from_start),
    .next_idx   (enc_next),
    .found      (enc_found)
  );

  always_comb begin
    state_d    = state_q;
    mask_d     = mask_q;
    rd_sel_d   = rd_sel_q;
    out_data_d = out_data_q;
    out_idx_d  = out_idx_q;
    unique case (state_q)
      IDLE: begin
        if (Start) begin
          mask_d = Mask;
          if (enc_found) begin
            rd_sel_d = enc_next;
            state_d  = SELECT;
          end else begin
            state_d = FINISH;
          end
        end
      end
      SELECT: begin
        out_data_d = Rd_data;
        out_idx_d  = rd_sel_q;
        state_d    = SEND;
      end
      SEND: begin
        if (Out_ready) begin
          if (enc_found) begin
            rd_sel_d = enc_next;
            state_d  = SELECT;
          end else begin
            state_d = FINISH;
          end
        end
      end
      FINISH: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_q    <= IDLE;
      mask_q     <= '0;
      rd_sel_q   <= '0;
      out_data_q <= '0;
      out_idx_q  <= '0;
    end else begin
      state_q    <= state_d;
      mask_q     <= mask_d;
      rd_sel_q   <= rd_sel_d;
      out_data_q <= out_data_d;
      out_idx_q  <= out_idx_d;
    end
  end

  assign Rd_sel    = rd_sel_q;
  assign Out_valid = (state_q == SEND);
  assign Out_data  = out_data_q;
  assign Out_idx   = out_idx_q;
  assign Busy      = (state_q != IDLE);
  assign Done      = (state_q == FINISH);

endmodule

// File: tb/tb_regfile_dump.sv
// Directed bench for regfile_dump with a behavioural register-file model.
module tb_regfile_dump;

  logic        Clk;
  logic        Reset;
  logic        Start;
  logic [7:0]  Mask;
  logic [2:0]  Rd_sel;
  logic [15:0] Rd_data;
  logic        Out_valid;
  logic        Out_ready;
  logic [15:0] Out_data;
  logic [2:0]  Out_idx;
  logic        Busy;
  logic        Done;

  logic [15:0] regs [8];
  int checks;
  int errors;

  assign Rd_data = regs[Rd_sel];

  regfile_dump dut (
    .Clk       (Clk),
    .Reset     (Reset),
    .Start     (Start),
    .Mask      (Mask),
    .Rd_sel    (Rd_sel),
    .Rd_data   (Rd_data),
    .Out_valid (Out_valid),
    .Out_ready (Out_ready),
    .Out_data  (Out_data),
    .Out_idx   (Out_idx),
    .Busy      (Busy),
    .Done      (Done)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  task automatic step();
    @(posedge Clk);
    #1;
  endtask

  // Leaves the bench in cycle 1 (the cycle after the accepting edge).
  task automatic pulse_start(input logic [7:0] m);
    Mask  = m;
    Start = 1'b1;
    step();
    Start = 1'b0;
  endtask

  task automatic test_reset();
    Reset = 1'b1;
    step();
    step();
    checks++;
    if ({Rd_sel, Out_valid, Out_data, Out_idx, Busy, Done} !== 24'd0) begin
      errors++;
      $display("FAIL reset_outputs got sel=%0d v=%0b d=%h i=%0d b=%0b dn=%0b want all zero",
               Rd_sel, Out_valid, Out_data, Out_idx, Busy, Done);
    end
    Reset = 1'b0;
    step();
  endtask

  task automatic test_full_dump();
    logic exp_valid;
    int   exp_i;
    Out_ready = 1'b1;
    pulse_start(8'hFF);
    for (int cyc = 1; cyc <= 18; cyc++) begin
      exp_valid = (cyc >= 2) && (cyc <= 16) && (cyc % 2 == 0);
      checks++;
      if (Out_valid !== exp_valid) begin
        errors++;
        $display("FAIL full_valid cyc=%0d got %0b want %0b", cyc, Out_valid, exp_valid);
      end
      if (exp_valid) begin
        exp_i = (cyc - 2) / 2;
        checks++;
        if (Out_idx !== 3'(exp_i) || Out_data !== 16'h1000 + 16'(exp_i)) begin
          errors++;
          $display("FAIL full_beat cyc=%0d got idx=%0d data=%h want idx=%0d data=%h",
                   cyc, Out_idx, Out_data, exp_i, 16'h1000 + 16'(exp_i));
        end
      end
      checks++;
      if (Done !== (cyc == 17) || Busy !== (cyc <= 17)) begin
        errors++;
        $display("FAIL full_done_busy cyc=%0d got done=%0b busy=%0b want done=%0b busy=%0b",
                 cyc, Done, Busy, cyc == 17, cyc <= 17);
      end
      step();
    end
  endtask

  task automatic test_sparse_backpressure();
    logic [2:0]  exp_idx [3];
    logic [15:0] held_data;
    logic [2:0]  held_idx;
    logic        in_beat;
    int beats, dones, w;
    exp_idx[0] = 3'd0;
    exp_idx[1] = 3'd2;
    exp_idx[2] = 3'd7;
    beats = 0; dones = 0; w = 0; in_beat = 1'b0;
    held_data = '0; held_idx = '0;
    Out_ready = 1'b0;
    pulse_start(8'b1000_0101);
    for (int cyc = 1; cyc <= 40; cyc++) begin
      if (Done) dones++;
      if (Out_valid) begin
        if (!in_beat) begin
          in_beat   = 1'b1;
          held_data = Out_data;
          held_idx  = Out_idx;
          w         = 0;
          checks++;
          if (beats > 2 || Out_idx !== exp_idx[beats > 2 ? 2 : beats] ||
              Out_data !== 16'h1000 + 16'(Out_idx)) begin
            errors++;
            $display("FAIL sparse_beat n=%0d got idx=%0d data=%h", beats, Out_idx, Out_data);
          end
        end else begin
          checks++;
          if (Out_data !== held_data || Out_idx !== held_idx) begin
            errors++;
            $display("FAIL sparse_stable got idx=%0d data=%h want idx=%0d data=%h",
                     Out_idx, Out_data, held_idx, held_data);
          end
        end
        Out_ready = (w >= 3);
        if (Out_ready) begin
          beats++;
          in_beat = 1'b0;
        end
        w++;
      end else begin
        Out_ready = 1'b0;
      end
      step();
    end
    Out_ready = 1'b0;
    checks++;
    if (beats !== 3 || dones !== 1) begin
      errors++;
      $display("FAIL sparse_counts got beats=%0d dones=%0d want 3 and 1", beats, dones);
    end
  endtask

  task automatic test_empty_mask();
    Out_ready = 1'b1;
    pulse_start(8'h00);
    checks++;
    if (Done !== 1'b1 || Busy !== 1'b1 || Out_valid !== 1'b0) begin
      errors++;
      $display("FAIL empty_cycle1 got done=%0b busy=%0b valid=%0b want 1 1 0",
               Done, Busy, Out_valid);
    end
    step();
    checks++;
    if (Done !== 1'b0 || Busy !== 1'b0 || Out_valid !== 1'b0) begin
      errors++;
      $display("FAIL empty_cycle2 got done=%0b busy=%0b valid=%0b want 0 0 0",
               Done, Busy, Out_valid);
    end
  endtask

  task automatic test_start_while_busy();
    int beats, dones;
    logic [2:0] seen [4];
    beats = 0; dones = 0;
    Out_ready = 1'b0;
    pulse_start(8'h18);
    step();
    checks++;
    if (Out_valid !== 1'b1 || Out_idx !== 3'd3) begin
      errors++;
      $display("FAIL busy_first got valid=%0b idx=%0d want 1 3", Out_valid, Out_idx);
    end
    Mask  = 8'h01;
    Start = 1'b1;
    step();
    Start = 1'b0;
    Out_ready = 1'b1;
    for (int cyc = 0; cyc < 12; cyc++) begin
      if (Done) dones++;
      if (Out_valid) begin
        if (beats < 4) seen[beats] = Out_idx;
        beats++;
      end
      step();
    end
    checks++;
    if (beats !== 2 || seen[0] !== 3'd3 || seen[1] !== 3'd4 || dones !== 1) begin
      errors++;
      $display("FAIL busy_ignore got beats=%0d first=%0d second=%0d dones=%0d want 2 3 4 1",
               beats, seen[0], seen[1], dones);
    end
  endtask

  task automatic test_capture_isolation();
    regs[5] = 16'hBEEF;
    Out_ready = 1'b0;
    pulse_start(8'h20);
    step();
    checks++;
    if (Out_valid !== 1'b1 || Out_data !== 16'hBEEF || Out_idx !== 3'd5) begin
      errors++;
      $display("FAIL iso_capture got valid=%0b data=%h idx=%0d want 1 beef 5",
               Out_valid, Out_data, Out_idx);
    end
    regs[5] = 16'h1234;
    step();
    checks++;
    if (Out_valid !== 1'b1 || Out_data !== 16'hBEEF) begin
      errors++;
      $display("FAIL iso_hold got valid=%0b data=%h want 1 beef", Out_valid, Out_data);
    end
    Out_ready = 1'b1;
    step();
    checks++;
    if (Done !== 1'b1 || Out_valid !== 1'b0) begin
      errors++;
      $display("FAIL iso_done got done=%0b valid=%0b want 1 0", Done, Out_valid);
    end
    Out_ready = 1'b0;
    regs[5] = 16'h1005;
    step();
  endtask

  task automatic test_reset_mid_dump();
    int dones;
    dones = 0;
    Out_ready = 1'b1;
    pulse_start(8'h03);
    step();
    step();
    step();
    checks++;
    if (Out_valid !== 1'b1 || Out_idx !== 3'd1 || Out_data !== 16'h1001) begin
      errors++;
      $display("FAIL rst_pre got valid=%0b idx=%0d data=%h want 1 1 1001",
               Out_valid, Out_idx, Out_data);
    end
    Out_ready = 1'b0;
    Reset = 1'b1;
    step();
    Reset = 1'b0;
    checks++;
    if ({Rd_sel, Out_valid, Out_data, Out_idx, Busy, Done} !== 24'd0) begin
      errors++;
      $display("FAIL rst_mid got sel=%0d v=%0b d=%h i=%0d b=%0b dn=%0b want all zero",
               Rd_sel, Out_valid, Out_data, Out_idx, Busy, Done);
    end
    for (int cyc = 0; cyc < 4; cyc++) begin
      if (Done || Busy) dones++;
      step();
    end
    checks++;
    if (dones !== 0) begin
      errors++;
      $display("FAIL rst_quiet got %0d active cycles want 0", dones);
    end
    pulse_start(8'h80);
    checks++;
    if (Rd_sel !== 3'd7 || Busy !== 1'b1) begin
      errors++;
      $display("FAIL rst_restart_sel got sel=%0d busy=%0b want 7 1", Rd_sel, Busy);
    end
    step();
    checks++;
    if (Out_valid !== 1'b1 || Out_idx !== 3'd7 || Out_data !== 16'h1007) begin
      errors++;
      $display("FAIL rst_restart_beat got valid=%0b idx=%0d data=%h want 1 7 1007",
               Out_valid, Out_idx, Out_data);
    end
    Out_ready = 1'b1;
    step();
    checks++;
    if (Done !== 1'b1) begin
      errors++;
      $display("FAIL rst_restart_done got %0b want 1", Done);
    end
    Out_ready = 1'b0;
    step();
  endtask

  initial begin
    checks    = 0;
    errors    = 0;
    Reset     = 1'b0;
    Start     = 1'b0;
    Mask      = 8'h00;
    Out_ready = 1'b0;
    for (int i = 0; i < 8; i++) regs[i] = 16'h1000 + 16'(i);
    #2;
    test_reset();
    test_full_dump();
    test_sparse_backpressure();
    test_empty_mask();
    test_start_while_busy();
    test_capture_isolation();
    test_reset_mid_dump();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/regfile_dump.md
Name: regfile_dump

Overview:
- Sequential reader for the 8x16 LC-3 register file, used for debug and display.
- On a Start pulse it walks the registers selected by a mask, lowest index first. For each one it drives the read-select and captures the combinational read data.
- It presents each {index, value} pair on a valid/ready stream toward the hex-display or UART front end.
- It drives the SR1 read-select only while Busy; the top level muxes the CPU's SR1 select with Rd_sel using Busy.

Parameters:
NUM_REGS, 8, number of registers walked; mask width.
DATA_W, 16, register width.
IDX_W, 3, register index width; equals log2(NUM_REGS).

Ports:
Clk  input  1  system clock; all state changes on rising edge.
Reset  input  1  synchronous, active-high reset.
Start  input  1  one-cycle request to begin a dump; sampled only in IDLE.
Mask  input  NUM_REGS  registers to dump; bit i selects Ri; latched on accepted Start.
Rd_sel  output  IDX_W  register-file read select (SR1 path); registered.
Rd_data  input  DATA_W  combinational register-file read data for Rd_sel.
Out_valid  output  1  Out_data/Out_idx hold a captured register.
Out_ready  input  1  downstream accepts when Out_valid && Out_ready at a rising edge.
Out_data  output  DATA_W  captured register value.
Out_idx  output  IDX_W  index of captured register.
Busy  output  1  high in every state except IDLE.
Done  output  1  one-cycle pulse when a dump completes.

Behaviour:
Reset values:
- State IDLE; Rd_sel=0, Out_valid=0, Out_data=0, Out_idx=0, Busy=0, Done=0.
- Latched mask cleared.
- Reset in any state aborts the dump on the next edge; no Done pulse is issued.

States: IDLE, SELECT, SEND, FINISH.

IDLE:
- Start=1 with Mask!=0: latch Mask, set idx to the lowest set bit, Rd_sel<=idx, go to SELECT.
- Start=1 with Mask==0: go directly to FINISH.
- Start=0: stay in IDLE.

SELECT:
- Lasts exactly one cycle so Rd_sel settles through the register-file mux.
- At the end of the cycle: Out_data<=Rd_data, Out_idx<=Rd_sel, Out_valid<=1, go to SEND.

SEND:
- Out_valid=1; Out_data and Out_idx are held stable until the handshake completes.
- Rd_data changes during SEND do not affect Out_data.
- On the handshake edge: Out_valid<=0.
  - If a set mask bit exists above idx: idx<=next set bit, Rd_sel<=idx, go to SELECT.
  - Otherwise go to FINISH.
- Out_ready=0 stalls indefinitely with no timeout.

FINISH:
- Done=1 for exactly one cycle, then go to IDLE.
- Busy is still 1 in FINISH.

Timing:
- Start accepted at edge 0 → SELECT in cycle 1 → Out_valid=1 from cycle 2.
- With Out_ready held at 1: one register every 2 cycles.
- Full 8-register dump: Done high in cycle 17.

Boundary rules:
- Start while Busy is ignored; the latched mask is not modified.
- Mask input changes after acceptance are ignored.
- Rd_sel holds its last value after the dump (don't-care while Busy=0).
- Index never wraps: R7 is the final candidate.
- Out_ready while Out_valid=0 has no effect.

Decomposition:
Package regfile_dump_pkg:
- State enum dump_state_t {IDLE, SELECT, SEND, FINISH}.
- Constants NUM_REGS, DATA_W, IDX_W.

Sub-module regfile_next_idx (combinational priority encoder):
- Inputs: mask, current idx, and a "from start" flag.
- Outputs: next set index strictly above idx (or lowest set bit when "from start" is set), plus a found flag.
- Used both for the first selection and for every advance.

Test Plan:
- Full dump: reg model R0..R7=0x1000+i, Mask=0xFF, Out_ready=1 → 8 beats, Out_idx 0..7, Out_data 0x1000..0x1007, Done in cycle 17, Busy=0 in cycle 18.
- Sparse with backpressure: Mask=8'b1000_0101, Out_ready low 3 cycles per beat → exactly 3 beats idx 2,0? No — idx 0,2,7 in order; Out_data stable through every stall; one Done pulse.
- Empty mask: Start with Mask=0 → no Out_valid, Done pulses cycle 1, Busy high only in cycle 1.
- Start/Mask during dump: second Start with Mask=0x01 while in SEND of idx 3 (first Mask=0x18) → beats only idx 3,4; no restart.
- Capture isolation: change R5 model value from 0xBEEF to 0x1234 during SEND of idx 5 → Out_data remains 0xBEEF until the handshake.
- Reset mid-dump: assert Reset in SEND of second beat → next cycle all outputs zero, state IDLE, no Done; a new Start with Mask=0x80 dumps R7 correctly.
